fpnew_i2fcast_iter: RTL and testbench

Iterative integer-to-floating-point cast unit for the FPnew conversion path, the counterpart of the float-to-integer cast. It accepts a signed or unsigned integer of any enabled integer format and returns the correctly rounded value in one fixed destination FP format, with IEEE status flags. To save area it normalises with a byte-stepping shifter over several cycles instead of a full-width barrel shifter. It uses a valid/ready handshake on both sides, so the surrounding opgroup can stall it.

---
 rtl/fpnew_pkg.sv | 92 +++++++++
 rtl/fpnew_rounding.sv | 41 ++++
 rtl/fpnew_i2fcast_iter.sv | 206 ++++++++++++++++++++
 tb/tb_fpnew_i2fcast_iter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpnew_pkg.sv
// FPnew shared types and format helpers used by the conversion opgroup.
// Includes the coarse normalisation step width of the iterative int-to-float cast.
package fpnew_pkg;

    localparam int unsigned NUM_INT_FORMATS = 4;
    localparam int unsigned I2F_COARSE_STEP = 8;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef enum logic [1:0] {
        INT8  = 2'd0,
        INT16 = 2'd1,
        INT32 = 2'd2,
        INT64 = 2'd3
    } int_format_e;

    typedef logic [0:NUM_INT_FORMATS-1] ifmt_logic_t;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        ROD = 3'b101,
        DYN = 3'b111
    } roundmode_e;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    typedef struct packed {
        int unsigned exp_bits;
        int unsigned man_bits;
    } fp_encoding_t;

    function automatic fp_encoding_t fp_encoding(fp_format_e fmt);
        case (fmt)
            FP64:    return '{11, 52};
            FP16:    return '{5, 10};
            FP8:     return '{5, 2};
            FP16ALT: return '{8, 7};
            default: return '{8, 23};
        endcase
    endfunction

    function automatic int unsigned exp_bits(fp_format_e fmt);
        return fp_encoding(fmt).exp_bits;
    endfunction

    function automatic int unsigned man_bits(fp_format_e fmt);
        return fp_encoding(fmt).man_bits;
    endfunction

    function automatic int unsigned fp_width(fp_format_e fmt);
        return exp_bits(fmt) + man_bits(fmt) + 1;
    endfunction

    function automatic int unsigned bias(fp_format_e fmt);
        return (1 << (exp_bits(fmt) - 1)) - 1;
    endfunction

    function automatic int unsigned int_width(int_format_e ifmt);
        case (ifmt)
            INT8:    return 8;
            INT16:   return 16;
            INT32:   return 32;
            default: return 64;
        endcase
    endfunction

    function automatic int unsigned max_int_width(ifmt_logic_t cfg);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < NUM_INT_FORMATS; i++) begin
            if (cfg[i] && int_width(int_format_e'(i)) > res) res = int_width(int_format_e'(i));
        end
        return res;
    endfunction

endpackage

// File: rtl/fpnew_rounding.sv
// Rounds a packed {exponent, mantissa} magnitude by one ulp according to the IEEE rounding mode.
module fpnew_rounding import fpnew_pkg::*; #(
    parameter int unsigned AbsWidth = 2
) (
    input  logic [AbsWidth-1:0] abs_value_i,
    input  logic                sign_i,
    input  logic [1:0]          round_sticky_bits_i,
    input  roundmode_e          rnd_mode_i,
    input  logic                effective_subtraction_i,
    output logic [AbsWidth-1:0] abs_rounded_o,
    output logic                sign_o,
    output logic                exact_zero_o
);

    logic round_up;

    always_comb begin
        round_up = 1'b0;
        case (rnd_mode_i)
            RNE: begin
                case (round_sticky_bits_i)
                    2'b10:   round_up = abs_value_i[0];
                    2'b11:   round_up = 1'b1;
                    default: round_up = 1'b0;
                endcase
            end
            RTZ: round_up = 1'b0;
            RDN: round_up = (|round_sticky_bits_i) & sign_i;
            RUP: round_up = (|round_sticky_bits_i) & ~sign_i;
            RMM: round_up = round_sticky_bits_i[1];
            ROD: round_up = ~abs_value_i[0] & (|round_sticky_bits_i);
            default: round_up = 1'b0;
        endcase
    end

    // A carry out of the mantissa field naturally bumps the exponent field.
    assign abs_rounded_o = abs_value_i + AbsWidth'(round_up);
    assign exact_zero_o  = (abs_value_i == '0) && (round_sticky_bits_i == 2'b00);
    assign sign_o        = (exact_zero_o && effective_subtraction_i) ? (rnd_mode_i == RDN) : sign_i;

endmodule

// File: rtl/fpnew_i2fcast_iter.sv
// Iterative integer-to-float cast: byte-stepping normaliser followed by one rounding cycle.
// Define FPNEW_I2F_HOLD_BYPASS_EN to accept a new operand on the edge a held result is consumed.
module fpnew_i2fcast_iter import fpnew_pkg::*; #(
    parameter fp_format_e   DstFpFormat  = FP32,
    parameter ifmt_logic_t  IntFmtConfig = '1,
    parameter type          TagType      = logic,
    localparam int unsigned SRC_WIDTH    = max_int_width(IntFmtConfig),
    localparam int unsigned DST_WIDTH    = fp_width(DstFpFormat)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [SRC_WIDTH-1:0] operands_i,
    input  roundmode_e           rnd_mode_i,
    input  logic                 op_mod_i,
    input  int_format_e          int_fmt_i,
    input  TagType               tag_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 flush_i,
    output logic [DST_WIDTH-1:0] result_o,
    output status_t              status_o,
    output TagType               tag_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 busy_o
);

    localparam int unsigned EXP_BITS = exp_bits(DstFpFormat);
    localparam int unsigned MAN_BITS = man_bits(DstFpFormat);
    localparam int unsigned BIAS     = bias(DstFpFormat);
    localparam int unsigned EW       = EXP_BITS + 2;
    localparam int unsigned LZ_W     = $clog2(I2F_COARSE_STEP);
    localparam int unsigned PAD_W    = SRC_WIDTH + MAN_BITS + 2;
    localparam int unsigned MAX_EXP  = (1 << EXP_BITS) - 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] NORM = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]           state_q, state_d;
    logic                 load;
    logic [SRC_WIDTH-1:0] ext, abs_in, abs_q, abs_norm;
    logic                 fill_bit, sign_in, sign_q;
    logic signed [EW-1:0] exp_q, exp_norm;
    roundmode_e           rnd_q;
    TagType               tag_q;

    logic [I2F_COARSE_STEP-1:0]     top_byte;
    logic                           coarse;
    logic [LZ_W-1:0]                lz;
    logic [PAD_W-1:0]               abs_pad;
    logic [MAN_BITS-1:0]            mantissa;
    logic                           round_bit, sticky;
    logic [EW:0]                    biased_exp;
    logic [EXP_BITS+MAN_BITS-1:0]   rounded;
    logic                           rnd_sign, unused_exact_zero;
    logic                           of, to_inf;
    logic [DST_WIDTH-1:0]           res_fine;
    status_t                        st_fine;

    // Operand extension from the selected integer width to SRC_WIDTH.
    always_comb begin
        int unsigned src_w;
        src_w = int_width(int_fmt_i);
        if (src_w > SRC_WIDTH) src_w = SRC_WIDTH;
        fill_bit = 1'b0;
        ext      = '0;
        for (int unsigned i = 0; i < SRC_WIDTH; i++) begin
            if (i + 1 == src_w) fill_bit = ~op_mod_i & operands_i[i];
        end
        for (int unsigned i = 0; i < SRC_WIDTH; i++) begin
            ext[i] = (i < src_w) ? operands_i[i] : fill_bit;
        end
    end

    assign sign_in = ~op_mod_i & ext[SRC_WIDTH-1];
    assign abs_in  = sign_in ? -ext : ext;

    assign top_byte = abs_q[SRC_WIDTH-1 -: I2F_COARSE_STEP];
    assign coarse   = (abs_q != '0) && (top_byte == '0);

    always_comb begin
        lz = '0;
        for (int unsigned i = 0; i < I2F_COARSE_STEP; i++) begin
            if (top_byte[i]) lz = LZ_W'(I2F_COARSE_STEP - 1 - i);
        end
    end

    assign abs_norm   = abs_q << lz;
    assign exp_norm   = exp_q - EW'(lz);
    assign abs_pad    = {abs_norm, {(MAN_BITS + 2){1'b0}}};
    assign mantissa   = abs_pad[PAD_W-2 -: MAN_BITS];
    assign round_bit  = abs_pad[PAD_W-2-MAN_BITS];
    assign sticky     = |abs_pad[PAD_W-3-MAN_BITS:0];
    // exp_norm is never negative for a non-zero operand, so the biased value is compared unsigned.
    assign biased_exp = {exp_norm[EW-1], exp_norm} + (EW + 1)'(BIAS);

    fpnew_rounding #(
        .AbsWidth (EXP_BITS + MAN_BITS)
    ) i_rounding (
        .abs_value_i             ({biased_exp[EXP_BITS-1:0], mantissa}),
        .sign_i                  (sign_q),
        .round_sticky_bits_i     ({round_bit, sticky}),
        .rnd_mode_i              (rnd_q),
        .effective_subtraction_i (1'b0),
        .abs_rounded_o           (rounded),
        .sign_o                  (rnd_sign),
        .exact_zero_o            (unused_exact_zero)
    );

    assign of = (biased_exp >= (EW + 1)'(MAX_EXP))
              || (rounded[EXP_BITS+MAN_BITS-1 -: EXP_BITS] == '1);

    always_comb begin
        res_fine   = {rnd_sign, rounded};
        st_fine    = '0;
        st_fine.NX = round_bit | sticky;
        case (rnd_q)
            RTZ:     to_inf = 1'b0;
            RDN:     to_inf = sign_q;
            RUP:     to_inf = ~sign_q;
            default: to_inf = 1'b1;
        endcase
        if (abs_q == '0) begin
            res_fine = '0;
            st_fine  = '0;
        end else if (of) begin
            st_fine.OF = 1'b1;
            st_fine.NX = 1'b1;
            res_fine   = to_inf ? {sign_q, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}}
                                : {sign_q, {(EXP_BITS - 1){1'b1}}, 1'b0, {MAN_BITS{1'b1}}};
        end
    end

    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        in_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    load    = 1'b1;
                    state_d = NORM;
                end
            end
            NORM: if (!coarse) state_d = HOLD;
            HOLD: begin
`ifdef FPNEW_I2F_HOLD_BYPASS_EN
                in_ready_o = out_ready_i;
                if (out_ready_i) begin
                    if (in_valid_i) begin
                        load    = 1'b1;
                        state_d = NORM;
                    end else begin
                        state_d = IDLE;
                    end
                end
`else
                if (out_ready_i) state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
            load    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            abs_q    <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            rnd_q    <= RNE;
            tag_q    <= '0;
            result_o <= '0;
            status_o <= '0;
            tag_o    <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                abs_q  <= abs_in;
                exp_q  <= EW'(SRC_WIDTH - 1);
                sign_q <= sign_in;
                rnd_q  <= rnd_mode_i;
                tag_q  <= tag_i;
            end else if (state_q == NORM && !flush_i) begin
                if (coarse) begin
                    abs_q <= abs_q << I2F_COARSE_STEP;
                    exp_q <= exp_q - EW'(I2F_COARSE_STEP);
                end else begin
                    result_o <= res_fine;
                    status_o <= st_fine;
                    tag_o    <= tag_q;
                end
            end
        end
    end

    assign out_valid_o = (state_q == HOLD);
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_fpnew_i2fcast_iter.sv
// Directed vector bench for fpnew_i2fcast_iter (FP32 and FP16 instances) plus stall/flush/reset sequences.
module tb_fpnew_i2fcast_iter;
    import fpnew_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [63:0] operands;
    roundmode_e  rnd;
    logic        op_mod;
    int_format_e int_fmt;
    logic        tag;
    logic        in_valid32, in_valid16, flush, out_ready;

    logic        in_ready32, out_valid32, busy32, tag32;
    logic [31:0] res32;
    status_t     st32;
    logic        in_ready16, out_valid16, busy16, tag16;
    logic [15:0] res16;
    status_t     st16;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fpnew_i2fcast_iter #(.DstFpFormat(FP32), .IntFmtConfig('1), .TagType(logic)) dut32 (
        .clk_i(clk), .rst_ni(rst_ni), .operands_i(operands), .rnd_mode_i(rnd), .op_mod_i(op_mod),
        .int_fmt_i(int_fmt), .tag_i(tag), .in_valid_i(in_valid32), .in_ready_o(in_ready32),
        .flush_i(flush), .result_o(res32), .status_o(st32), .tag_o(tag32),
        .out_valid_o(out_valid32), .out_ready_i(out_ready), .busy_o(busy32)
    );

    fpnew_i2fcast_iter #(.DstFpFormat(FP16), .IntFmtConfig('1), .TagType(logic)) dut16 (
        .clk_i(clk), .rst_ni(rst_ni), .operands_i(operands), .rnd_mode_i(rnd), .op_mod_i(op_mod),
        .int_fmt_i(int_fmt), .tag_i(tag), .in_valid_i(in_valid16), .in_ready_o(in_ready16),
        .flush_i(flush), .result_o(res16), .status_o(st16), .tag_o(tag16),
        .out_valid_o(out_valid16), .out_ready_i(out_ready), .busy_o(busy16)
    );

    typedef struct {
        logic        fp16;
        logic [63:0] op;
        int_format_e fmt;
        logic        umod;
        roundmode_e  rm;
        logic [31:0] res;
        logic [4:0]  st;
        int          lat;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_valid32(output int cyc);
        cyc = 0;
        while (!out_valid32 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic consume;
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   cyc;
        logic t;
        t = idx[0];
        @(negedge clk);
        operands = v.op; int_fmt = v.fmt; op_mod = v.umod; rnd = v.rm; tag = t;
        if (v.fp16) in_valid16 = 1'b1; else in_valid32 = 1'b1;
        #1 check($sformatf("v%0d.in_ready", idx), v.fp16 ? in_ready16 : in_ready32, 1);
        @(posedge clk); #1;
        in_valid16 = 1'b0; in_valid32 = 1'b0;
        cyc = 0;
        while (!(v.fp16 ? out_valid16 : out_valid32) && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check($sformatf("v%0d.latency", idx), cyc, v.lat);
        check($sformatf("v%0d.result", idx), v.fp16 ? {16'h0, res16} : res32, v.res);
        check($sformatf("v%0d.status", idx), v.fp16 ? st16 : st32, v.st);
        check($sformatf("v%0d.tag", idx), v.fp16 ? tag16 : tag32, t);
        consume();
        check($sformatf("v%0d.busy_after", idx), v.fp16 ? busy16 : busy32, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

    initial begin
        int   cyc;
        logic seen;

        //            fp16  operand                 fmt    uns   rm   result        status   lat
        vecs[0]  = '{1'b0, 64'hFFFF_FFFF,          INT32, 1'b0, RNE, 32'hBF80_0000, 5'b00000, 8};
        vecs[1]  = '{1'b0, 64'hFFFF_FFFF,          INT32, 1'b1, RNE, 32'h4F80_0000, 5'b00001, 5};
        vecs[2]  = '{1'b0, 64'h0100_0001,          INT32, 1'b0, RNE, 32'h4B80_0000, 5'b00001, 5};
        vecs[3]  = '{1'b0, 64'h8000_0000_0000_0000, INT64, 1'b0, RNE, 32'hDF00_0000, 5'b00000, 1};
        vecs[4]  = '{1'b0, 64'h0,                  INT64, 1'b0, RNE, 32'h0000_0000, 5'b00000, 1};
        vecs[5]  = '{1'b1, 64'hFFF0,               INT32, 1'b1, RNE, 32'h0000_7C00, 5'b00101, 7};
        vecs[6]  = '{1'b1, 64'hFFF0,               INT32, 1'b1, RTZ, 32'h0000_7BFF, 5'b00001, 7};
        vecs[7]  = '{1'b1, 64'hFFFF_0010,          INT32, 1'b0, RUP, 32'h0000_FBFF, 5'b00001, 7};
        vecs[8]  = '{1'b0, 64'hDEAD_BE80,          INT8,  1'b0, RNE, 32'hC300_0000, 5'b00000, 8};
        vecs[9]  = '{1'b0, 64'h1234_FFFF,          INT16, 1'b1, RNE, 32'h477F_FF00, 5'b00000, 7};
        vecs[10] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, INT64, 1'b1, RDN, 32'h5F7F_FFFF, 5'b00001, 1};
        vecs[11] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, INT64, 1'b1, RUP, 32'h5F80_0000, 5'b00001, 1};
        vecs[12] = '{1'b1, 64'hFFFF_0010,          INT32, 1'b0, RDN, 32'h0000_FC00, 5'b00101, 7};
        vecs[13] = '{1'b1, 64'hFFF0,               INT32, 1'b1, RMM, 32'h0000_7C00, 5'b00101, 7};
        vecs[14] = '{1'b1, 64'h0001_1170,          INT32, 1'b1, RTZ, 32'h0000_7BFF, 5'b00101, 6};
        vecs[15] = '{1'b1, 64'hFFFE_EE90,          INT32, 1'b0, RUP, 32'h0000_FBFF, 5'b00101, 6};

        rst_ni = 1'b1; operands = '0; rnd = RNE; op_mod = 1'b0; int_fmt = INT32; tag = 1'b0;
        in_valid32 = 1'b0; in_valid16 = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        check("reset.in_ready", in_ready32, 1);
        check("reset.out_valid", out_valid32, 0);
        check("reset.busy", busy32, 0);
        check("reset.result", res32, 0);
        check("reset.status", st32, 0);
        check("reset.tag", tag32, 0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Stall in HOLD, then consume while a second operand is waiting.
        @(negedge clk);
        operands = 64'd5; int_fmt = INT32; op_mod = 1'b0; rnd = RNE; tag = 1'b1; in_valid32 = 1'b1;
        @(posedge clk); #1;
        operands = 64'd7; tag = 1'b0;
        wait_valid32(cyc);
        check("stall.latency", cyc, 8);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("stall%0d.result", i), res32, 32'h40A0_0000);
            check($sformatf("stall%0d.tag", i), tag32, 1);
            check($sformatf("stall%0d.in_ready", i), in_ready32, 0);
            check($sformatf("stall%0d.out_valid", i), out_valid32, 1);
        end
        @(negedge clk) out_ready = 1'b1;
`ifdef FPNEW_I2F_HOLD_BYPASS_EN
        #1 check("bypass.in_ready", in_ready32, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bypass.busy", busy32, 1);
        check("bypass.out_valid", out_valid32, 0);
        in_valid32 = 1'b0;
`else
        #1 check("nobypass.in_ready", in_ready32, 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("nobypass.busy", busy32, 0);
        check("nobypass.in_ready_idle", in_ready32, 1);
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        check("nobypass.accept", busy32, 1);
`endif
        wait_valid32(cyc);
        check("second.latency", cyc, 8);
        check("second.result", res32, 32'h40E0_0000);
        check("second.tag", tag32, 0);
        consume();

        // Flush during a coarse normalisation step.
        @(negedge clk);
        operands = 64'd1; op_mod = 1'b1; tag = 1'b1; in_valid32 = 1'b1;
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        @(posedge clk); #1;
        check("flush.busy_before", busy32, 1);
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1;
        check("flush.busy", busy32, 0);
        check("flush.out_valid", out_valid32, 0);
        check("flush.result_kept", res32, 32'h40E0_0000);
        @(negedge clk) flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid32) seen = 1'b1;
        end
        check("flush.no_valid", seen, 0);

        // Asynchronous reset in the middle of NORM.
        @(negedge clk);
        operands = 64'd1; tag = 1'b1; in_valid32 = 1'b1;
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        check("midrst.busy_before", busy32, 1);
        rst_ni = 1'b0;
        #1;
        check("midrst.in_ready", in_ready32, 1);
        check("midrst.out_valid", out_valid32, 0);
        check("midrst.busy", busy32, 0);
        check("midrst.result", res32, 0);
        check("midrst.status", st32, 0);
        check("midrst.tag", tag32, 0);
        @(negedge clk) rst_ni = 1'b1;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
